complex_vxc_chunk_sequencer: RTL and testbench
==============================================

Name: complex_vxc_chunk_sequencer

Overview:
- Initiator side of the complex vector×constant ±vector datapath (NI lanes, 64-bit complex elements).
- On `start`, reads both operand vectors chunk-by-chunk from operand memory and presents each chunk to the datapath with a valid strobe.
- Captures the datapath result LAT cycles after each issue and writes it back to result memory with a per-lane mask that suppresses padding elements.
- Pulses `done` when the last chunk has been written.

Parameters:
- NOE, 16, number of complex elements per vector (≥1).
- NI, 8, lanes per chunk.
- element_width, 64, bits per complex element: [63:32] real, [31:0] imag.
- LAT, 8, datapath latency in cycles from `dp_valid` to valid `dp_result`.
- AW, 8, memory address width; requires NCH ≤ 2^AW.
- Derived: NCH = ceil(NOE/NI). No extra chunk is added when NOE%NI==0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an operation.
- op_in  in  1  0 = add, 1 = subtract; latched at start.
- constant_in  in  element_width  complex multiplier; latched at start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  operand memory read strobe.
- rd_addr  out  AW  chunk index of the read.
- rd_data_a  in  element_width*NI  first-row chunk; valid 1 cycle after rd_en.
- rd_data_b  in  element_width*NI  second-row chunk; valid 1 cycle after rd_en.
- dp_first  out  element_width*NI  operand chunk to datapath; registered rd_data_a.
- dp_second  out  element_width*NI  operand chunk to datapath; registered rd_data_b.
- dp_constant  out  element_width  latched constant.
- dp_op  out  1  latched op.
- dp_valid  out  1  dp_first/dp_second hold a valid chunk.
- dp_result  in  element_width*NI  datapath output.
- wr_en  out  1  result memory write strobe.
- wr_addr  out  AW  result chunk index.
- wr_data  out  element_width*NI  registered dp_result; masked lanes forced to 0.
- wr_lane_en  out  NI  per-lane write enable.

Behaviour:
- Reset (asynchronous, `reset`=0): all outputs 0; state IDLE; counters and valid pipe cleared. Asserting reset mid-operation aborts the operation immediately, with no write and no `done`.
- Lane ordering: lane j occupies bits [element_width*(NI-j)-1 -: element_width] and carries element chunk*NI+j.
- States:
  - IDLE: `start`=1 latches op/constant, clears counters, sets `busy`, goes to ISSUE.
  - ISSUE: `rd_en`=1 each cycle with `rd_addr` = 0..NCH-1. After the last address, go to DRAIN.
  - DRAIN: wait until the write count reaches NCH, then go to DONE.
  - DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- Timing, with `start` sampled high in cycle 0:
  - `rd_en` high in cycles 1..NCH.
  - `dp_valid` high in cycles 2..NCH+1.
  - A LAT-deep shift register of `dp_valid` marks result capture in cycles 2+LAT..NCH+1+LAT.
  - `wr_en` is registered: high in cycles 3+LAT..NCH+2+LAT, with `wr_addr` = 0..NCH-1 in order.
  - `done` is high in cycle NCH+3+LAT.
- `dp_first`/`dp_second` hold their last value when `dp_valid`=0.
- `wr_lane_en`: all ones, except for the final chunk, where lanes j < R are 1 and the rest are 0, with R = NOE-(NCH-1)*NI. When R=NI the final chunk is all ones.
- `wr_data` lanes with `wr_lane_en`=0 are driven to 0.
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored. `start` is accepted in the first IDLE cycle after DONE.
- Counters are wide enough for NCH with no wrap. `rd_addr` and `wr_addr` never exceed NCH-1.
- NCH=1: ISSUE lasts 1 cycle, and a single write occurs with the partial mask if applicable.

Test Plan:
- NOE=16, NI=8, LAT=8, start at cycle 0 → `rd_en` in cycles 1–2 (addr 0,1); `dp_valid` in cycles 2–3; `wr_en` in cycles 11–12 (addr 0,1, `wr_lane_en`=8'hFF both); `done` only in cycle 13; `busy` high in cycles 1–12.
- NOE=13, NI=8 → NCH=2; second write has `wr_lane_en`=8'hF8 (lanes 0–4); lanes 5–7 of `wr_data`=0.
- op_in=1, constant_in=64'h00000002_00000000, then op_in/constant_in toggled during busy → `dp_op`=1 and `dp_constant` unchanged through done; `dp_result` stub value 64'hA per lane appears unaltered in `wr_data`.
- `start` pulsed in cycles 5 and 13 (done cycle) → no restart, single `done`; `start` in cycle 14 → new operation, `rd_en` in cycle 15.
- Reset driven low asynchronously in cycle 6 → all outputs 0 within the same cycle; no `wr_en`/`done` afterward; a new start after reset release runs a full clean sequence.
- NOE=5, NI=8 (NCH=1) → one read, one write with `wr_lane_en`=8'hF8, `done` in cycle 12.

Source files
------------

// File: rtl/complex_vxc_chunk_sequencer_if.sv
// Bus bundle between the chunk sequencer and its controller, operand memory,
// complex vector x constant datapath and result memory.
interface complex_vxc_chunk_sequencer_if #(
    parameter int unsigned NI     = 8,
    parameter int unsigned ELEM_W = 64,
    parameter int unsigned AW     = 8
);
    localparam int unsigned CHUNK_W = ELEM_W * NI;

    logic               start;
    logic               op_in;
    logic [ELEM_W-1:0]  constant_in;
    logic               busy;
    logic               done;

    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [CHUNK_W-1:0] rd_data_a;
    logic [CHUNK_W-1:0] rd_data_b;

    logic [CHUNK_W-1:0] dp_first;
    logic [CHUNK_W-1:0] dp_second;
    logic [ELEM_W-1:0]  dp_constant;
    logic               dp_op;
    logic               dp_valid;
    logic [CHUNK_W-1:0] dp_result;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [CHUNK_W-1:0] wr_data;
    logic [NI-1:0]      wr_lane_en;

    modport master (
        input  start, op_in, constant_in, rd_data_a, rd_data_b, dp_result,
        output busy, done, rd_en, rd_addr, dp_first, dp_second, dp_constant,
               dp_op, dp_valid, wr_en, wr_addr, wr_data, wr_lane_en
    );

    modport slave (
        output start, op_in, constant_in, rd_data_a, rd_data_b, dp_result,
        input  busy, done, rd_en, rd_addr, dp_first, dp_second, dp_constant,
               dp_op, dp_valid, wr_en, wr_addr, wr_data, wr_lane_en
    );
endinterface

// File: rtl/complex_vxc_chunk_sequencer.sv
// Streams operand chunks to the complex vector x constant +/- vector datapath
// and writes the results back with padding lanes masked off.
module complex_vxc_chunk_sequencer #(
    parameter int unsigned NOE    = 16,
    parameter int unsigned NI     = 8,
    parameter int unsigned ELEM_W = 64,
    parameter int unsigned LAT    = 8,
    parameter int unsigned AW     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    complex_vxc_chunk_sequencer_if.master  bus
);
    localparam int unsigned CHUNK_W = ELEM_W * NI;
    localparam int unsigned NCH     = (NOE + NI - 1) / NI;
    localparam int unsigned REM     = NOE - (NCH - 1) * NI;
    localparam int unsigned CNT_W   = $clog2(NCH + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NCH - 1);
    localparam logic [CNT_W-1:0] NCH_CNT   = CNT_W'(NCH);
    // Lane 0 sits in the MSB, so the valid lanes of a short last chunk are the top REM bits.
    localparam logic [NI-1:0]    LAST_MASK = ~({NI{1'b1}} >> REM);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic               op_q;
    logic [ELEM_W-1:0]  const_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [CHUNK_W-1:0] dp_first_q;
    logic [CHUNK_W-1:0] dp_second_q;
    logic               dp_valid_q;
    logic [LAT-1:0]     vpipe_q;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [CHUNK_W-1:0] wr_data_q;
    logic [NI-1:0]      wr_lane_en_q;

    logic               capture;
    logic [NI-1:0]      lane_en_d;
    logic [CHUNK_W-1:0] wr_data_d;

    assign capture = vpipe_q[LAT-1];

    // Lane mask for the chunk being captured; disabled lanes are zeroed.
    always_comb begin
        lane_en_d = (wr_cnt_q == LAST_IDX) ? LAST_MASK : '1;
        wr_data_d = '0;
        for (int b = 0; b < int'(NI); b++) begin
            if (lane_en_d[b]) begin
                wr_data_d[ELEM_W*b +: ELEM_W] = bus.dp_result[ELEM_W*b +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            op_q         <= 1'b0;
            const_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            dp_first_q   <= '0;
            dp_second_q  <= '0;
            dp_valid_q   <= 1'b0;
            vpipe_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_lane_en_q <= '0;
        end else begin
            done_q     <= 1'b0;
            dp_valid_q <= rd_en_q;
            if (rd_en_q) begin
                dp_first_q  <= bus.rd_data_a;
                dp_second_q <= bus.rd_data_b;
            end
            vpipe_q <= LAT'({vpipe_q, dp_valid_q});
            wr_en_q <= capture;
            if (capture) begin
                wr_addr_q    <= AW'(wr_cnt_q);
                wr_data_q    <= wr_data_d;
                wr_lane_en_q <= lane_en_d;
                wr_cnt_q     <= wr_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op_in;
                        const_q  <= bus.constant_in;
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (wr_cnt_q == NCH_CNT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = AW'(rd_cnt_q);
    assign bus.dp_first    = dp_first_q;
    assign bus.dp_second   = dp_second_q;
    assign bus.dp_constant = const_q;
    assign bus.dp_op       = op_q;
    assign bus.dp_valid    = dp_valid_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_lane_en  = wr_lane_en_q;
endmodule

// File: tb/tb_complex_vxc_chunk_sequencer.sv
// Directed bench: three sequencers (NOE=16, 13, 5) with an operand memory model,
// a LAT-deep datapath pass-through on the first and constant stubs on the others.
module tb_complex_vxc_chunk_sequencer;
    localparam int unsigned NI  = 8;
    localparam int unsigned EW  = 64;
    localparam int unsigned LAT = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned CW  = EW * NI;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    complex_vxc_chunk_sequencer_if #(.NI(NI), .ELEM_W(EW), .AW(AW)) bus_a ();
    complex_vxc_chunk_sequencer_if #(.NI(NI), .ELEM_W(EW), .AW(AW)) bus_b ();
    complex_vxc_chunk_sequencer_if #(.NI(NI), .ELEM_W(EW), .AW(AW)) bus_c ();

    complex_vxc_chunk_sequencer #(.NOE(16), .NI(NI), .ELEM_W(EW), .LAT(LAT), .AW(AW))
        u_a (.clk(clk), .reset(reset), .bus(bus_a));
    complex_vxc_chunk_sequencer #(.NOE(13), .NI(NI), .ELEM_W(EW), .LAT(LAT), .AW(AW))
        u_b (.clk(clk), .reset(reset), .bus(bus_b));
    complex_vxc_chunk_sequencer #(.NOE(5), .NI(NI), .ELEM_W(EW), .LAT(LAT), .AW(AW))
        u_c (.clk(clk), .reset(reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memory content: element e of a row is {base+e, base+0x100+e}; lane 0 in the MSB.
    function automatic logic [CW-1:0] chunk(input int unsigned addr, input logic [31:0] base);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < int'(NI); j++) begin
            v[EW*(NI-j)-1 -: EW] = {32'(base + 32'(addr*NI + j)), 32'(base + 32'h100 + 32'(addr*NI + j))};
        end
        return v;
    endfunction

    always_comb begin
        bus_a.rd_data_a = chunk(int'(bus_a.rd_addr), 32'h1000);
        bus_a.rd_data_b = chunk(int'(bus_a.rd_addr), 32'h2000);
        bus_b.rd_data_a = chunk(int'(bus_b.rd_addr), 32'h3000);
        bus_b.rd_data_b = chunk(int'(bus_b.rd_addr), 32'h4000);
        bus_c.rd_data_a = chunk(int'(bus_c.rd_addr), 32'h5000);
        bus_c.rd_data_b = chunk(int'(bus_c.rd_addr), 32'h6000);
    end

    // Datapath model for u_a: dp_first delayed LAT cycles.
    logic [CW-1:0] dpp [LAT];
    always @(posedge clk) begin
        dpp[0] <= bus_a.dp_first;
        for (int i = 1; i < int'(LAT); i++) dpp[i] <= dpp[i-1];
    end
    assign bus_a.dp_result = dpp[LAT-1];
    assign bus_b.dp_result = {NI{64'h0000_0000_0000_000A}};
    assign bus_c.dp_result = {NI{64'h0000_0000_0000_0005}};

    logic nz_a, nz_b, nz_c;
    assign nz_a = |{bus_a.busy, bus_a.done, bus_a.rd_en, bus_a.rd_addr, bus_a.dp_first, bus_a.dp_second,
                    bus_a.dp_constant, bus_a.dp_op, bus_a.dp_valid, bus_a.wr_en, bus_a.wr_addr,
                    bus_a.wr_data, bus_a.wr_lane_en};
    assign nz_b = |{bus_b.busy, bus_b.done, bus_b.rd_en, bus_b.rd_addr, bus_b.dp_first, bus_b.dp_second,
                    bus_b.dp_constant, bus_b.dp_op, bus_b.dp_valid, bus_b.wr_en, bus_b.wr_addr,
                    bus_b.wr_data, bus_b.wr_lane_en};
    assign nz_c = |{bus_c.busy, bus_c.done, bus_c.rd_en, bus_c.rd_addr, bus_c.dp_first, bus_c.dp_second,
                    bus_c.dp_constant, bus_c.dp_op, bus_c.dp_valid, bus_c.wr_en, bus_c.wr_addr,
                    bus_c.wr_data, bus_c.wr_lane_en};

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus_a.start = 1'b0; bus_a.op_in = 1'b0; bus_a.constant_in = '0;
        bus_b.start = 1'b0; bus_b.op_in = 1'b0; bus_b.constant_in = '0;
        bus_c.start = 1'b0; bus_c.op_in = 1'b0; bus_c.constant_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (nz_a !== 1'b0) begin failures++; $display("FAIL reset_outs_a got %b exp 0", nz_a); end
        checks++; if (nz_b !== 1'b0) begin failures++; $display("FAIL reset_outs_b got %b exp 0", nz_b); end
        checks++; if (nz_c !== 1'b0) begin failures++; $display("FAIL reset_outs_c got %b exp 0", nz_c); end
        reset = 1'b1;
        next_cycle();
        checks++; if (nz_a !== 1'b0) begin failures++; $display("FAIL idle_outs_a got %b exp 0", nz_a); end
    endtask

    // Full NOE=16 sequence on u_a, start sampled at the end of cycle 0.
    task automatic test_basic(input string tag);
        logic [EW-1:0] k;
        logic e_busy, e_done, e_rd, e_dv, e_wr;
        k = 64'h0000_0003_0000_0001;
        bus_a.op_in = 1'b0; bus_a.constant_in = k; bus_a.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            bus_a.start = 1'b0;
            e_busy = (c <= 12); e_done = (c == 13); e_rd = (c <= 2);
            e_dv = (c >= 2 && c <= 3); e_wr = (c >= 11 && c <= 12);
            checks++; if (bus_a.busy !== e_busy) begin failures++; $display("FAIL %s busy c=%0d got %b exp %b", tag, c, bus_a.busy, e_busy); end
            checks++; if (bus_a.done !== e_done) begin failures++; $display("FAIL %s done c=%0d got %b exp %b", tag, c, bus_a.done, e_done); end
            checks++; if (bus_a.rd_en !== e_rd) begin failures++; $display("FAIL %s rd_en c=%0d got %b exp %b", tag, c, bus_a.rd_en, e_rd); end
            checks++; if (bus_a.dp_valid !== e_dv) begin failures++; $display("FAIL %s dp_valid c=%0d got %b exp %b", tag, c, bus_a.dp_valid, e_dv); end
            checks++; if (bus_a.wr_en !== e_wr) begin failures++; $display("FAIL %s wr_en c=%0d got %b exp %b", tag, c, bus_a.wr_en, e_wr); end
            checks++; if (bus_a.dp_constant !== k || bus_a.dp_op !== 1'b0) begin failures++; $display("FAIL %s dp_const c=%0d got %h/%b exp %h/0", tag, c, bus_a.dp_constant, bus_a.dp_op, k); end
            if (e_rd) begin
                checks++; if (bus_a.rd_addr !== AW'(c-1)) begin failures++; $display("FAIL %s rd_addr c=%0d got %0d exp %0d", tag, c, bus_a.rd_addr, c-1); end
            end
            if (e_dv) begin
                checks++; if (bus_a.dp_first !== chunk(c-2, 32'h1000)) begin failures++; $display("FAIL %s dp_first c=%0d got %h", tag, c, bus_a.dp_first); end
                checks++; if (bus_a.dp_second !== chunk(c-2, 32'h2000)) begin failures++; $display("FAIL %s dp_second c=%0d got %h", tag, c, bus_a.dp_second); end
            end
            if (e_wr) begin
                checks++; if (bus_a.wr_addr !== AW'(c-11)) begin failures++; $display("FAIL %s wr_addr c=%0d got %0d exp %0d", tag, c, bus_a.wr_addr, c-11); end
                checks++; if (bus_a.wr_lane_en !== 8'hFF) begin failures++; $display("FAIL %s wr_lane_en c=%0d got %h exp ff", tag, c, bus_a.wr_lane_en); end
                checks++; if (bus_a.wr_data !== chunk(c-11, 32'h1000)) begin failures++; $display("FAIL %s wr_data c=%0d got %h", tag, c, bus_a.wr_data); end
            end
        end
    endtask

    task automatic test_const_latch;
        logic [EW-1:0] k;
        k = 64'h0000_0002_0000_0000;
        bus_a.op_in = 1'b1; bus_a.constant_in = k; bus_a.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            next_cycle();
            bus_a.start = 1'b0;
            if (c == 3) begin bus_a.op_in = 1'b0; bus_a.constant_in = 64'hDEAD_BEEF_1234_5678; end
            if (c == 6) begin bus_a.op_in = 1'b1; bus_a.constant_in = 64'h1111_2222_3333_4444; end
            if (c <= 13) begin
                checks++; if (bus_a.dp_op !== 1'b1) begin failures++; $display("FAIL latch dp_op c=%0d got %b exp 1", c, bus_a.dp_op); end
                checks++; if (bus_a.dp_constant !== k) begin failures++; $display("FAIL latch dp_constant c=%0d got %h exp %h", c, bus_a.dp_constant, k); end
            end
            checks++; if (bus_a.done !== (c == 13)) begin failures++; $display("FAIL latch done c=%0d got %b exp %b", c, bus_a.done, (c == 13)); end
        end
        bus_a.op_in = 1'b0; bus_a.constant_in = '0;
    endtask

    task automatic test_start_ignored;
        logic e_rd, e_done, e_busy;
        bus_a.op_in = 1'b0; bus_a.constant_in = 64'h7; bus_a.start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            next_cycle();
            e_rd   = (c == 1 || c == 2 || c == 15 || c == 16);
            e_done = (c == 13 || c == 27);
            e_busy = (c <= 12) || (c >= 15 && c <= 26);
            checks++; if (bus_a.rd_en !== e_rd) begin failures++; $display("FAIL restart rd_en c=%0d got %b exp %b", c, bus_a.rd_en, e_rd); end
            checks++; if (bus_a.done !== e_done) begin failures++; $display("FAIL restart done c=%0d got %b exp %b", c, bus_a.done, e_done); end
            checks++; if (bus_a.busy !== e_busy) begin failures++; $display("FAIL restart busy c=%0d got %b exp %b", c, bus_a.busy, e_busy); end
            bus_a.start = (c == 5 || c == 13 || c == 14);
        end
        bus_a.start = 1'b0;
    endtask

    task automatic test_partial;
        logic [CW-1:0] full, part;
        full = {NI{64'h0000_0000_0000_000A}};
        part = '0;
        for (int j = 0; j < 5; j++) part[EW*(NI-j)-1 -: EW] = 64'hA;
        bus_b.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            next_cycle();
            bus_b.start = 1'b0;
            checks++; if (bus_b.wr_en !== (c == 11 || c == 12)) begin failures++; $display("FAIL partial wr_en c=%0d got %b", c, bus_b.wr_en); end
            checks++; if (bus_b.done !== (c == 13)) begin failures++; $display("FAIL partial done c=%0d got %b", c, bus_b.done); end
            if (c == 11) begin
                checks++; if (bus_b.wr_lane_en !== 8'hFF) begin failures++; $display("FAIL partial lane_en0 got %h exp ff", bus_b.wr_lane_en); end
                checks++; if (bus_b.wr_data !== full) begin failures++; $display("FAIL partial wr_data0 got %h exp %h", bus_b.wr_data, full); end
            end
            if (c == 12) begin
                checks++; if (bus_b.wr_addr !== 8'd1) begin failures++; $display("FAIL partial wr_addr1 got %0d exp 1", bus_b.wr_addr); end
                checks++; if (bus_b.wr_lane_en !== 8'hF8) begin failures++; $display("FAIL partial lane_en1 got %h exp f8", bus_b.wr_lane_en); end
                checks++; if (bus_b.wr_data !== part) begin failures++; $display("FAIL partial wr_data1 got %h exp %h", bus_b.wr_data, part); end
            end
        end
    endtask

    task automatic test_single_chunk;
        logic [CW-1:0] part;
        part = '0;
        for (int j = 0; j < 5; j++) part[EW*(NI-j)-1 -: EW] = 64'h5;
        bus_c.start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            bus_c.start = 1'b0;
            checks++; if (bus_c.rd_en !== (c == 1)) begin failures++; $display("FAIL single rd_en c=%0d got %b", c, bus_c.rd_en); end
            checks++; if (bus_c.dp_valid !== (c == 2)) begin failures++; $display("FAIL single dp_valid c=%0d got %b", c, bus_c.dp_valid); end
            checks++; if (bus_c.wr_en !== (c == 11)) begin failures++; $display("FAIL single wr_en c=%0d got %b", c, bus_c.wr_en); end
            checks++; if (bus_c.done !== (c == 12)) begin failures++; $display("FAIL single done c=%0d got %b", c, bus_c.done); end
            checks++; if (bus_c.busy !== (c <= 11)) begin failures++; $display("FAIL single busy c=%0d got %b", c, bus_c.busy); end
            if (c == 2) begin
                checks++; if (bus_c.dp_first !== chunk(0, 32'h5000)) begin failures++; $display("FAIL single dp_first got %h", bus_c.dp_first); end
            end
            if (c == 11) begin
                checks++; if (bus_c.wr_addr !== 8'd0) begin failures++; $display("FAIL single wr_addr got %0d exp 0", bus_c.wr_addr); end
                checks++; if (bus_c.wr_lane_en !== 8'hF8) begin failures++; $display("FAIL single lane_en got %h exp f8", bus_c.wr_lane_en); end
                checks++; if (bus_c.wr_data !== part) begin failures++; $display("FAIL single wr_data got %h exp %h", bus_c.wr_data, part); end
            end
        end
    endtask

    task automatic test_reset_abort;
        bus_a.op_in = 1'b1; bus_a.constant_in = 64'h99; bus_a.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            bus_a.start = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (nz_a !== 1'b0) begin failures++; $display("FAIL abort outs_a got %b exp 0", nz_a); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            checks++; if ({bus_a.wr_en, bus_a.done, bus_a.busy, bus_a.rd_en} !== 4'b0) begin
                failures++; $display("FAIL abort quiet c=%0d got wr_en=%b done=%b busy=%b rd_en=%b exp 0",
                                     c, bus_a.wr_en, bus_a.done, bus_a.busy, bus_a.rd_en);
            end
        end
        test_basic("post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic("basic");
        test_const_latch();
        test_start_ignored();
        test_partial();
        test_single_chunk();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
